// File: rtl/sha3_pkg.sv
// sha3_pkg: FSM states and word geometry shared by the keccak byte packer.
package sha3_pkg;
  typedef enum logic [1:0] {FILL, HOLD, TERM, DONE} state_e;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_NUM_W = 2;
  localparam int WORD_W = 32;
endpackage

// File: rtl/keccak_byte_packer_if.sv
// keccak_byte_packer_if: byte stream side plus keccak core word port.
// msg_len and LEN_W exist only when KECCAK_PACKER_LEN_EN is defined.
interface keccak_byte_packer_if import sha3_pkg::*;;
`ifdef KECCAK_PACKER_LEN_EN
  parameter int LEN_W = 32;
  logic [LEN_W-1:0] msg_len;
`endif
  logic [7:0] s_data;
  logic s_valid, s_last, s_ready;
  logic [WORD_W-1:0] in;
  logic in_ready, is_last, buffer_full, done;
  logic [BYTE_NUM_W-1:0] byte_num;
  modport master(
    input s_data, s_valid, s_last, buffer_full,
    output s_ready, in, in_ready, is_last, byte_num, done
`ifdef KECCAK_PACKER_LEN_EN
    , output msg_len
`endif
  );
  modport slave(
    output s_data, s_valid, s_last, buffer_full,
    input s_ready, in, in_ready, is_last, byte_num, done
`ifdef KECCAK_PACKER_LEN_EN
    , input msg_len
`endif
  );
endinterface

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: packs a valid/ready/last byte stream into keccak core words.
// KECCAK_PACKER_LEN_EN adds a saturating accepted-byte counter on msg_len.
module keccak_byte_packer import sha3_pkg::*; (
  input  logic clk,
  input  logic reset,
  keccak_byte_packer_if.master bus
);
  state_e state_q, state_d;
  logic [BYTE_NUM_W-1:0] cnt_q, cnt_d, byte_num_q, byte_num_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic is_last_q, is_last_d, term_q, term_d, full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FILL;
      cnt_q <= '0;
      word_q <= '0;
      is_last_q <= 1'b0;
      byte_num_q <= '0;
      term_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      is_last_q <= is_last_d;
      byte_num_q <= byte_num_d;
      term_q <= term_d;
    end
  // word_q is cleared after every hand-off, so OR-ing lanes in leaves unused lanes zero
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    word_d = word_q;
    is_last_d = is_last_q;
    byte_num_d = byte_num_q;
    term_d = term_q;
    full = cnt_q == BYTE_NUM_W'(WORD_BYTES - 1);
    case (state_q)
      FILL: if (bus.s_valid) begin
        word_d = word_q | ({bus.s_data, (WORD_W - 8)'(0)} >> {cnt_q, 3'b000});
        cnt_d = cnt_q + 1'b1;
        state_d = (bus.s_last || full) ? HOLD : FILL;
        is_last_d = bus.s_last && !full;
        byte_num_d = (bus.s_last && !full) ? cnt_q + 1'b1 : '0;
        term_d = bus.s_last && full;
      end
      HOLD: if (!bus.buffer_full) begin
        state_d = is_last_q ? DONE : term_q ? TERM : FILL;
        cnt_d = '0;
        word_d = '0;
        is_last_d = is_last_q || term_q;
        term_d = 1'b0;
      end
      TERM: state_d = bus.buffer_full ? TERM : DONE;
      default: ;
    endcase
  end
  assign bus.s_ready = state_q == FILL;
  assign bus.in = word_q;
  assign bus.in_ready = state_q == HOLD || state_q == TERM;
  assign bus.is_last = is_last_q;
  assign bus.byte_num = byte_num_q;
  assign bus.done = state_q == DONE;
`ifdef KECCAK_PACKER_LEN_EN
  parameter int LEN_W = 32;
  logic [LEN_W-1:0] len_q, len_d;
  always_comb len_d = (bus.s_valid && state_q == FILL && len_q != '1) ? len_q + 1'b1 : len_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) len_q <= '0;
    else len_q <= len_d;
  assign bus.msg_len = len_q;
`endif
endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb_keccak_byte_packer: directed message table, back-pressure/reset corner sequences
// and random messages checked against a word-level packing model.
module tb_keccak_byte_packer;
  typedef struct packed {logic [31:0] w; logic l; logic [1:0] bn;} word_t;
  typedef struct {string msg; int nw; logic [31:0] first; word_t last;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  byte unsigned m[$];
  word_t exp_q[$], got[$];
  vec_t tv[6];
  keccak_byte_packer_if bus();
  keccak_byte_packer dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic void model();
    int n = m.size();
    word_t x;
    exp_q.delete();
    for (int i = 0; i < n; i += 4) begin
      int k = (n - i < 4) ? n - i : 4;
      x = '0;
      for (int j = 0; j < k; j++) x.w[31 - 8 * j -: 8] = m[i + j];
      if (k < 4) begin
        x.l = 1'b1;
        x.bn = k[1:0];
      end
      exp_q.push_back(x);
    end
    if (n % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
  endfunction
  function automatic void load(string s);
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    model();
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.s_data = 8'h0;
    bus.buffer_full = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {bus.in, bus.in_ready, bus.is_last, bus.byte_num, bus.done, bus.s_ready},
        {32'h0, 6'b000001});
`ifdef KECCAK_PACKER_LEN_EN
    chk("rst_len", bus.msg_len, 0);
`endif
  endtask
  task automatic run_msg(input int mode, input int vpct, input int bpct, output int cyc);
    int idx = 0, hold_n = 0;
    logic prev_stall = 1'b0, after_hold = 1'b0;
    word_t prev = '0, cur;
    got.delete();
    cyc = 0;
    while (!bus.done && cyc < 2000) begin
      bus.buffer_full = (mode == 2) ? (bus.in_ready && got.size() == 1 && hold_n < 5)
                                    : ($urandom_range(99) < bpct);
      if (mode == 2 && bus.buffer_full) hold_n++;
      bus.s_valid = idx < m.size() && $urandom_range(99) < vpct;
      bus.s_data = idx < m.size() ? m[idx] : 8'h0;
      bus.s_last = idx == m.size() - 1;
      cur = {bus.in, bus.is_last, bus.byte_num};
      if (prev_stall) chk("stall_stable", {cur, bus.in_ready}, {prev, 1'b1});
      if (after_hold) chk("hold_release", bus.in_ready, 0);
      after_hold = 1'b0;
      if (bus.in_ready) chk("s_ready_busy", bus.s_ready, 0);
      if (bus.in_ready && !bus.buffer_full) begin
        got.push_back(cur);
        after_hold = mode == 2 && got.size() == 2;
      end
      prev_stall = bus.in_ready && bus.buffer_full;
      prev = cur;
      if (bus.s_valid && bus.s_ready) idx++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("done", bus.done, 1);
    chk("bytes_taken", idx, m.size());
    if (mode == 2) chk("held5", hold_n, 5);
  endtask
  task automatic check_words();
    chk("word_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("word", got[i], exp_q[i]);
  endtask
  task automatic post_done();
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'($urandom);
      bus.s_last = i[0];
      bus.buffer_full = i[1];
      @(posedge clk);
      @(negedge clk);
      chk("done_hold", {bus.s_ready, bus.in_ready, bus.done}, 3'b001);
`ifdef KECCAK_PACKER_LEN_EN
      chk("len_frozen", bus.msg_len, m.size());
`endif
    end
    bus.s_valid = 1'b0;
  endtask
  initial begin
    int cyc, idx, n;
    word_t f, l;
    tv[0] = '{"Hello, world!", 4, 32'h48656C6C, {32'h21000000, 1'b1, 2'd1}};
    tv[1] = '{"Hello, world", 4, 32'h48656C6C, {32'h00000000, 1'b1, 2'd0}};
    tv[2] = '{"A", 1, 32'h41000000, {32'h41000000, 1'b1, 2'd1}};
    tv[3] = '{"ab", 1, 32'h61620000, {32'h61620000, 1'b1, 2'd2}};
    tv[4] = '{"abc", 1, 32'h61626300, {32'h61626300, 1'b1, 2'd3}};
    tv[5] = '{"abcd", 2, 32'h61626364, {32'h00000000, 1'b1, 2'd0}};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      load(tv[t].msg);
      run_msg(0, 100, 0, cyc);
      check_words();
      f = got.size() > 0 ? got[0] : '0;
      l = got.size() > 0 ? got[got.size() - 1] : '0;
      chk({"nwords ", tv[t].msg}, got.size(), tv[t].nw);
      chk({"first ", tv[t].msg}, f.w, tv[t].first);
      chk({"last ", tv[t].msg}, l, tv[t].last);
      chk({"cycles ", tv[t].msg}, cyc, m.size() + tv[t].nw);
      post_done();
    end
    do_reset();
    load("Hello, world!");
    run_msg(2, 100, 0, cyc);
    check_words();
    post_done();
    do_reset();
    bus.buffer_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(8'h41 + i);
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("hold_word", {bus.in_ready, bus.in}, {1'b1, 32'h41424344});
    #1 reset = 1'b1;
    #1 chk("async_drop", {bus.in_ready, bus.in, bus.s_ready}, {1'b0, 32'h0, 1'b1});
    #1 reset = 1'b0;
    bus.buffer_full = 1'b0;
    @(negedge clk);
    load("ABCDEFGH");
    idx = 0;
    n = 0;
    while (idx < 6 && n < 50) begin
      bus.s_valid = 1'b1;
      bus.s_data = m[idx];
      bus.s_last = 1'b0;
      if (bus.s_ready) idx++;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("six_bytes", idx, 6);
    do_reset();
    load("The quick brown fox.");
    run_msg(1, 80, 30, cyc);
    check_words();
    f = got.size() > 0 ? got[0] : '0;
    chk("fox_first", f.w, 32'h54686520);
    post_done();
    for (int r = 0; r < 25; r++) begin
      do_reset();
      m.delete();
      n = $urandom_range(40, 1);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      model();
      run_msg(1, 60, 30, cyc);
      check_words();
      post_done();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
